floppy_voice_alloc: RTL



---
 rtl/floppy_pkg.sv | 49 ++++
 rtl/note_to_period.sv | 56 +++++
 rtl/floppy_voice_alloc.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/floppy_pkg.sv
`default_nettype none
// ============================================================================
// Module   : floppy_pkg
// Brief    : Shared types and constants for the floppy voice allocator:
//            controller states, age limits and the base half-period table.
// Revision : 1.0 - initial release
// ============================================================================
package floppy_pkg;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_SEARCH = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Default bank geometry.
  localparam int NUM_VOICES_DEF = 6;
  localparam int SP_WIDTH_DEF   = 22;

  // Voice age saturates here; three bits hold it.
  localparam int AGE_MAX = 7;
  localparam int AGE_W   = 3;

  // Base half-period table entries are 22 bits wide.
  localparam int BASE_W = 22;

  // Half-period in 50 MHz clocks of pitch class n, taken for MIDI note n
  // (octave -1): round(50e6 / (2 * 440 * 2^((n-69)/12))).
  // Higher octaves are derived by right shifts.
  localparam logic [BASE_W-1:0] BASE [12] = '{
    22'd3057805, 22'd2886184, 22'd2724195, 22'd2571297,
    22'd2426982, 22'd2290766, 22'd2162195, 22'd2040840,
    22'd1926297, 22'd1818182, 22'd1716135, 22'd1619816
  };

  // Table lookup with a safe zero for the unused codes 12..15.
  function automatic logic [BASE_W-1:0] base_lookup(input logic [3:0] pc);
    logic [BASE_W-1:0] v;
    v = '0;
    if (pc < 4'd12) begin
      v = BASE[pc];
    end
    return v;
  endfunction

endpackage : floppy_pkg
`default_nettype wire

// File: rtl/note_to_period.sv
`default_nettype none
// ============================================================================
// Module   : note_to_period
// Brief    : Converts a MIDI note number into a half-period setpoint. The
//            note is split into octave and pitch class by repeated
//            subtraction of 12 (one step per clock); the pitch class then
//            indexes the base table and the octave shifts the result down.
// Revision : 1.0 - initial release
// ============================================================================
module note_to_period
  import floppy_pkg::*;
#(
  parameter int SP_WIDTH = SP_WIDTH_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_start,
  input  logic                i_abort,
  input  logic [6:0]          i_note,
  output logic                o_done,
  output logic [SP_WIDTH-1:0] o_sp
);

  logic              r_busy;
  logic [6:0]        r_rem;
  logic [3:0]        r_oct;
  logic [BASE_W-1:0] w_base;

  // Iterative octave reduction: rem/oct stay frozen after completion so the
  // setpoint remains valid until the next start.
  always_ff @(posedge clk) begin
    if (rst || i_abort) begin
      r_busy <= 1'b0;
      r_rem  <= '0;
      r_oct  <= '0;
    end else if (i_start) begin
      r_busy <= 1'b1;
      r_rem  <= i_note;
      r_oct  <= '0;
    end else if (r_busy) begin
      if (r_rem >= 7'd12) begin
        r_rem <= r_rem - 7'd12;
        r_oct <= r_oct + 1'b1;
      end else begin
        r_busy <= 1'b0;
      end
    end
  end

  // Done pulses on the single cycle the remainder drops below one octave.
  assign o_done = r_busy && (r_rem < 7'd12);
  assign w_base = base_lookup(r_rem[3:0]);
  assign o_sp   = SP_WIDTH'(w_base >> r_oct);

endmodule : note_to_period
`default_nettype wire

// File: rtl/floppy_voice_alloc.sv
`default_nettype none
// ============================================================================
// Module   : floppy_voice_alloc
// Brief    : MIDI note-on/note-off voice allocator for a bank of floppy
//            drives. Each accepted event is decoded to a setpoint, the voice
//            table is scanned for a match / free / oldest voice, and the
//            per-voice enable and setpoint outputs are updated in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module floppy_voice_alloc
  import floppy_pkg::*;
#(
  parameter int NUM_VOICES = NUM_VOICES_DEF,
  parameter int SP_WIDTH   = SP_WIDTH_DEF,
  parameter int MIN_NOTE   = 24,
  parameter int MAX_NOTE   = 83
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           ev_valid,
  output logic                           ev_ready,
  input  logic                           ev_on,
  input  logic [6:0]                     ev_note,
  input  logic                           all_off,
  output logic                           busy,
  output logic [NUM_VOICES-1:0]          f_en,
  output logic [NUM_VOICES*SP_WIDTH-1:0] f_sp
);

  localparam int                IDX_W      = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam logic [IDX_W-1:0]  c_LAST_IDX = IDX_W'(NUM_VOICES - 1);
  localparam logic [6:0]        c_MIN_NOTE = 7'(MIN_NOTE);
  localparam logic [6:0]        c_MAX_NOTE = 7'(MAX_NOTE);
  localparam logic [AGE_W-1:0]  c_AGE_MAX  = AGE_W'(AGE_MAX);

  // Controller
  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_accept;
  logic                  w_in_range;
  logic                  w_dec_start;
  logic                  w_dec_done;
  logic [SP_WIDTH-1:0]   w_sp;

  // Captured event
  logic                  r_ev_on;
  logic [6:0]            r_ev_note;
  logic                  r_in_range;

  // Voice table
  logic [NUM_VOICES-1:0] r_en;
  logic [SP_WIDTH-1:0]   r_sp   [NUM_VOICES];
  logic [6:0]            r_note [NUM_VOICES];
  logic [AGE_W-1:0]      r_age  [NUM_VOICES];

  // Scan results
  logic [IDX_W-1:0]      r_idx;
  logic                  r_match_found;
  logic [IDX_W-1:0]      r_match_idx;
  logic                  r_free_found;
  logic [IDX_W-1:0]      r_free_idx;
  logic [IDX_W-1:0]      r_old_idx;
  logic [AGE_W-1:0]      r_old_age;
  logic [IDX_W-1:0]      w_target;

  assign w_in_range = (ev_note >= c_MIN_NOTE) && (ev_note <= c_MAX_NOTE);

  // Note decoder: started only for in-range events, killed by panic.
  note_to_period #(
    .SP_WIDTH (SP_WIDTH)
  ) u_note_to_period (
    .clk     (clk),
    .rst     (rst),
    .i_start (w_dec_start),
    .i_abort (all_off),
    .i_note  (ev_note),
    .o_done  (w_dec_done),
    .o_sp    (w_sp)
  );

  // State register; panic drops any event in flight.
  always_ff @(posedge clk) begin
    if (rst || all_off) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode; out-of-range events go straight to
  // COMMIT, where they change nothing.
  always_comb begin
    w_state_nxt = r_state;
    ev_ready    = 1'b0;
    busy        = (r_state != ST_IDLE);
    w_accept    = 1'b0;
    w_dec_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        ev_ready = ~rst & ~all_off;
        w_accept = ev_valid & ev_ready;
        if (w_accept) begin
          if (w_in_range) begin
            w_state_nxt = ST_DECODE;
            w_dec_start = 1'b1;
          end else begin
            w_state_nxt = ST_COMMIT;
          end
        end
      end
      ST_DECODE: begin
        if (w_dec_done) begin
          w_state_nxt = ST_SEARCH;
        end
      end
      ST_SEARCH: begin
        if (r_idx == c_LAST_IDX) begin
          w_state_nxt = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture the event at acceptance so the source is free to move on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ev_on    <= 1'b0;
      r_ev_note  <= '0;
      r_in_range <= 1'b0;
    end else if (w_accept) begin
      r_ev_on    <= ev_on;
      r_ev_note  <= ev_note;
      r_in_range <= w_in_range;
    end
  end

  // Voice scan, one voice per cycle; results are cleared outside SEARCH so
  // every event starts from a clean slate. Oldest uses a strict compare so
  // ties keep the lower index.
  always_ff @(posedge clk) begin
    if (rst || (r_state != ST_SEARCH)) begin
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_old_idx     <= '0;
      r_old_age     <= '0;
    end else begin
      if (r_en[r_idx] && (r_note[r_idx] == r_ev_note)) begin
        r_match_found <= 1'b1;
        r_match_idx   <= r_idx;
      end
      if (!r_en[r_idx] && !r_free_found) begin
        r_free_found <= 1'b1;
        r_free_idx   <= r_idx;
      end
      if (r_age[r_idx] > r_old_age) begin
        r_old_idx <= r_idx;
        r_old_age <= r_age[r_idx];
      end
      r_idx <= r_idx + 1'b1;
    end
  end

  // Voice chosen for a note-on: retrigger, else lowest free, else oldest.
  always_comb begin
    w_target = r_old_idx;
    if (r_match_found) begin
      w_target = r_match_idx;
    end else if (r_free_found) begin
      w_target = r_free_idx;
    end
  end

  // Voice table update at COMMIT; panic clears enables and ages but leaves
  // the setpoints where they were.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_sp[i]   <= '0;
        r_note[i] <= '0;
        r_age[i]  <= '0;
      end
    end else if (all_off) begin
      r_en <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        r_age[i] <= '0;
      end
    end else if ((r_state == ST_COMMIT) && r_in_range) begin
      if (r_ev_on) begin
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (r_en[i] && (IDX_W'(i) != w_target) && (r_age[i] != c_AGE_MAX)) begin
            r_age[i] <= r_age[i] + 1'b1;
          end
        end
        r_age[w_target] <= '0;
        if (!r_match_found) begin
          r_en[w_target]   <= 1'b1;
          r_sp[w_target]   <= w_sp;
          r_note[w_target] <= r_ev_note;
        end
      end else if (r_match_found) begin
        r_en[r_match_idx]  <= 1'b0;
        r_age[r_match_idx] <= '0;
      end
    end
  end

  assign f_en = r_en;

  // Flatten the setpoint table onto the output bus.
  generate
    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_sp_pack
      assign f_sp[g*SP_WIDTH +: SP_WIDTH] = r_sp[g];
    end
  endgenerate

endmodule : floppy_voice_alloc
`default_nettype wire
